dm_regs: RTL

Debug Module register slave sitting directly downstream of the JTAG DTM. Accepts one DMI request at a time from the DTM's DMI port, decodes the RISC-V debug register address, and returns a DMI response. Owns dmcontrol/dmstatus/abstractcs/command/data0 and drives the halt, resume and abstract-command handshakes toward a single hart.

---
 rtl/dm_regs.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/dm_regs.sv
// dm_regs: RISC-V Debug Module register slave on the DTM's DMI port, serving one hart.
// Build option DM_HALTSUM_EN maps a read-only haltsum0 register at address 0x40.
module dm_regs #(
    parameter logic [31:0] HARTINFO = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmi_req_valid,
    output logic        dmi_req_ready,
    input  logic [6:0]  dmi_req_addr,
    input  logic [31:0] dmi_req_data,
    input  logic [1:0]  dmi_req_op,
    output logic        dmi_rsp_valid,
    input  logic        dmi_rsp_ready,
    output logic [31:0] dmi_rsp_data,
    output logic [1:0]  dmi_rsp_op,
    output logic        halt_req,
    output logic        resume_req,
    input  logic        hart_halted,
    output logic        ac_req,
    output logic [31:0] ac_cmd,
    input  logic        ac_done,
    output logic        ndmreset
);

    localparam logic [6:0] ADDR_DATA0      = 7'h04;
    localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
    localparam logic [6:0] ADDR_HARTINFO   = 7'h12;
    localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
    localparam logic [6:0] ADDR_COMMAND    = 7'h17;
`ifdef DM_HALTSUM_EN
    localparam logic [6:0] ADDR_HALTSUM0   = 7'h40;
`endif

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    localparam logic [1:0] RSP_OK   = 2'd0;
    localparam logic [1:0] RSP_FAIL = 2'd2;

    localparam logic [2:0] CMDERR_NONE    = 3'd0;
    localparam logic [2:0] CMDERR_BUSY    = 3'd1;
    localparam logic [2:0] CMDERR_NOTSUPP = 3'd2;

    typedef enum logic {IDLE, RSP} dmi_state_t;
    typedef enum logic {AC_IDLE, AC_BUSY} ac_state_t;

    dmi_state_t  dmi_state;
    ac_state_t   ac_state;

    logic [31:0] data0;
    logic        haltreq;
    logic        dmactive;
    logic        resumeack;
    logic [2:0]  cmderr;

    logic        busy;
    logic        accept;
    logic        reg_hit;
    logic [31:0] reg_rdata;
    logic [31:0] rsp_data_next;
    logic [1:0]  rsp_op_next;
    logic        wr_en;
    logic        wr_dmcontrol;
    logic        wr_data0;
    logic        wr_abstractcs;
    logic        wr_command;
    logic        resume_start;
    logic [31:0] dmcontrol_word;
    logic [31:0] dmstatus_word;
    logic [31:0] abstractcs_word;

    assign busy          = (ac_state == AC_BUSY);
    assign accept        = dmi_req_valid && (dmi_state == IDLE);
    assign dmi_req_ready = (dmi_state == IDLE);
    assign dmi_rsp_valid = (dmi_state == RSP);
    assign halt_req      = haltreq & dmactive;
    assign ac_req        = busy;

    assign dmcontrol_word  = {haltreq, 1'b0, 28'b0, ndmreset, dmactive};
    assign dmstatus_word   = {14'b0, {2{resumeack}}, 4'b0, {2{~hart_halted}},
                              {2{hart_halted}}, 1'b1, 3'b0, 4'd2};
    assign abstractcs_word = {19'b0, busy, 1'b0, cmderr, 4'b0, 4'd1};

    // Register decode; with the module inactive only dmcontrol reads back non-zero.
    always_comb begin
        reg_hit   = 1'b1;
        reg_rdata = '0;
        case (dmi_req_addr)
            ADDR_DATA0:      reg_rdata = data0;
            ADDR_DMCONTROL:  reg_rdata = dmcontrol_word;
            ADDR_DMSTATUS:   reg_rdata = dmstatus_word;
            ADDR_HARTINFO:   reg_rdata = HARTINFO;
            ADDR_ABSTRACTCS: reg_rdata = abstractcs_word;
            ADDR_COMMAND:    reg_rdata = '0;
`ifdef DM_HALTSUM_EN
            ADDR_HALTSUM0:   reg_rdata = {31'b0, hart_halted};
`endif
            default:         reg_hit = 1'b0;
        endcase
        if (!dmactive && (dmi_req_addr != ADDR_DMCONTROL)) begin
            reg_rdata = '0;
        end
    end

    always_comb begin
        rsp_data_next = '0;
        rsp_op_next   = RSP_OK;
        case (dmi_req_op)
            OP_NOP:   rsp_op_next = RSP_OK;
            OP_READ:  rsp_data_next = reg_rdata;
            OP_WRITE: rsp_op_next = reg_hit ? RSP_OK : RSP_FAIL;
            default:  rsp_op_next = RSP_FAIL;
        endcase
    end

    assign wr_en         = accept && (dmi_req_op == OP_WRITE) && reg_hit;
    assign wr_dmcontrol  = wr_en && (dmi_req_addr == ADDR_DMCONTROL);
    assign wr_data0      = wr_en && (dmi_req_addr == ADDR_DATA0);
    assign wr_abstractcs = wr_en && (dmi_req_addr == ADDR_ABSTRACTCS);
    assign wr_command    = wr_en && (dmi_req_addr == ADDR_COMMAND);
    assign resume_start  = wr_dmcontrol && dmi_req_data[30] && !dmi_req_data[31] && hart_halted;

    always_ff @(posedge clk) begin
        if (!rst) begin
            dmi_state    <= IDLE;
            ac_state     <= AC_IDLE;
            dmi_rsp_data <= '0;
            dmi_rsp_op   <= RSP_OK;
            data0        <= '0;
            haltreq      <= 1'b0;
            dmactive     <= 1'b0;
            ndmreset     <= 1'b0;
            resume_req   <= 1'b0;
            resumeack    <= 1'b0;
            cmderr       <= CMDERR_NONE;
            ac_cmd       <= '0;
        end else begin
            case (dmi_state)
                IDLE: begin
                    if (dmi_req_valid) begin
                        dmi_rsp_data <= rsp_data_next;
                        dmi_rsp_op   <= rsp_op_next;
                        dmi_state    <= RSP;
                    end
                end
                RSP: begin
                    if (dmi_rsp_ready) begin
                        dmi_rsp_data <= '0;
                        dmi_rsp_op   <= RSP_OK;
                        dmi_state    <= IDLE;
                    end
                end
            endcase

            if (wr_dmcontrol) begin
                haltreq  <= dmi_req_data[31];
                ndmreset <= dmi_req_data[1];
                dmactive <= dmi_req_data[0];
            end

            // An inactive module pins everything but dmcontrol to its reset value.
            if (!dmactive) begin
                data0      <= '0;
                cmderr     <= CMDERR_NONE;
                resume_req <= 1'b0;
                resumeack  <= 1'b0;
                ac_cmd     <= '0;
                ac_state   <= AC_IDLE;
            end else begin
                if (resume_start) begin
                    resume_req <= 1'b1;
                    resumeack  <= 1'b0;
                end else if (resume_req && !hart_halted) begin
                    resume_req <= 1'b0;
                    resumeack  <= 1'b1;
                end

                case (ac_state)
                    AC_IDLE: begin
                        if (wr_command && (cmderr == CMDERR_NONE)) begin
                            if (dmi_req_data[31:24] != 8'd0) begin
                                cmderr <= CMDERR_NOTSUPP;
                            end else begin
                                ac_cmd   <= dmi_req_data;
                                ac_state <= AC_BUSY;
                            end
                        end
                        if (wr_data0) begin
                            data0 <= dmi_req_data;
                        end
                        if (wr_abstractcs) begin
                            cmderr <= cmderr & ~dmi_req_data[10:8];
                        end
                    end
                    AC_BUSY: begin
                        if ((wr_data0 || wr_abstractcs || wr_command) && (cmderr == CMDERR_NONE)) begin
                            cmderr <= CMDERR_BUSY;
                        end
                        if (ac_done) begin
                            ac_state <= AC_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule
